paddle_led_mapper: RTL and testbench
====================================

// Module: paddle_led_mapper
// PURPOSE
//   Parametrised paddle position register and LED-index mapper for the LED Pong field.
//   - Holds the paddle centre position; moves it on up/down pulses or loads it directly.
//   - Presents all PADDLE_W LED indices in parallel.
//   - Streams the same indices one per beat, valid/ready, to the serial LED driver.
//   - Sits between the player input logic and the LED frame/driver logic.
// PARAMETERS
//   PADDLE_W   3    lights per paddle (>=1)
//   POS_MIN    1    lowest legal position
//   POS_MAX    8    highest legal position
//   RESET_POS  4    position after reset and substitute for an out-of-range load
//   STEP       30   LED index spacing between adjacent positions
//   IDX_W      9    LED index width; (POS_MAX+PADDLE_W-1)*STEP must fit, else $error at elaboration
//   POS_W      derived localparam = $clog2(POS_MAX+1)
// PORTS
//   clk          in   1              system clock
//   rst_n        in   1              asynchronous, active-low reset
//   pos_in       in   POS_W          absolute position for pos_load
//   pos_load     in   1              load pos_in (1-cycle strobe)
//   move_up      in   1              position +1 (1-cycle strobe)
//   move_down    in   1              position -1 (1-cycle strobe)
//   pos_out      out  POS_W          current position
//   led_idx      out  PADDLE_W*IDX_W  parallel indices; light i in bits [i*IDX_W +: IDX_W]
//   stream_idx   out  IDX_W          serial index beat
//   stream_valid out  1              stream_idx valid
//   stream_ready in   1              sink accepts the beat
//   stream_last  out  1              final beat of the frame (light PADDLE_W-1)
//   busy         out  1              stream frame in progress
// BEHAVIOUR
//   Mapping:
//     - idx(i) = (pos+i)*STEP, i = 0..PADDLE_W-1 (pos=1 -> 30,60,90).
//     - Constant multiply, truncated to IDX_W.
//   Reset (asynchronous):
//     - pos_out=RESET_POS, led_idx=map(RESET_POS).
//     - stream_valid=0, stream_last=0, busy=0, stream_idx=0.
//     - pending=1, so one frame is streamed right after reset release.
//   Command priority: pos_load > (move_up XOR move_down). Both moves high -> no move.
//   Load: a pos_in outside [POS_MIN,POS_MAX] loads RESET_POS.
//   Bounds:
//     - Default: moves saturate at POS_MIN/POS_MAX; a saturated move is no change.
//     - PADDLE_WRAP_EN behaviour is under CONFIGURATION.
//   Latency: pos_out and led_idx are registered and update on the edge that samples the command.
//     Command in cycle N -> new value visible in cycle N+1.
//   Change detection:
//     - Any change of pos_out sets pending.
//     - A load of the same value sets pending too (forces a refresh).
//   FSM states: IDLE, STREAM.
//     - IDLE & pending: snapshot pos, clear pending, beat=0, go to STREAM.
//       stream_valid rises the next cycle.
//     - STREAM: stream_idx=map(snapshot)[beat].
//       On valid&ready: beat+1. On the last beat, go to IDLE; busy falls the same edge.
//     - stream_valid stays high and stream_idx stays stable until ready (AXI-style, no retraction).
//     - Position changes during STREAM do not alter the frame in flight.
//       They set pending, and one new frame follows. Multiple changes collapse into one frame
//       carrying the latest position.
//     - Back-to-back: one IDLE cycle between frames.
//     - PADDLE_W=1: every beat has stream_last=1.
//   Reset mid-frame aborts the stream immediately; no partial-frame completion.
// CONFIGURATION
//   PADDLE_WRAP_EN defined:
//     - move_up at POS_MAX -> POS_MIN; move_down at POS_MIN -> POS_MAX.
//     - A wrap always sets pending.
//   PADDLE_WRAP_EN undefined: saturating behaviour as above.
// STRUCTURE
//   paddle_pkg: state enum {IDLE, STREAM}.
//   paddle_pkg: function paddle_map(pos, i), the shared mapping.
//   paddle_pkg: localparam defaults for STEP/IDX_W so other LED blocks stay consistent.
//   Sub-module paddle_idx_stream: snapshot, beat counter, valid/ready FSM, last flag.
//   Top level keeps the position register, command decode and parallel led_idx.
// TESTING
//   1 Reset release, ready=1 -> beats 120,150,180, last on 180; pos_out=4; busy low after 3 beats.
//   2 pos_load pos_in=1 -> next cycle led_idx={90,60,30}; one frame 30,60,90.
//     pos_in=9 and pos_in=0 -> pos_out=4.
//   3 Six move_up from pos 4 -> pos_out saturates at 8, led_idx={300,270,240}.
//     Under PADDLE_WRAP_EN the 5th pulse gives pos_out=1.
//   4 move_up and move_down in the same cycle -> pos_out unchanged, no frame.
//     pos_load and move_up together -> load wins.
//   5 ready held low 5 cycles mid-frame, two moves during the frame:
//     - stream_idx is stable while stalled; the current frame is unaltered.
//     - Exactly one new frame follows, carrying pos+2.
//   6 rst_n asserted on beat 2 -> stream_valid=0 and busy=0 at once.
//     After release, a fresh frame for RESET_POS.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared types and LED-index mapping for the LED Pong paddle blocks.
// Other LED blocks import the STEP/IDX_W defaults from here to stay consistent.
package paddle_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

  localparam int unsigned PADDLE_STEP  = 30;
  localparam int unsigned PADDLE_IDX_W = 9;

  // LED index of light i for a paddle centred at pos; callers truncate to their index width.
  function automatic logic [31:0] paddle_map(input logic [31:0] pos,
                                             input logic [31:0] i,
                                             input logic [31:0] step = PADDLE_STEP);
    return (pos + i) * step;
  endfunction

endpackage

// File: rtl/paddle_idx_stream.sv
// Serialises the paddle LED indices one beat at a time over valid/ready.
// The position is snapshotted at frame start so in-flight frames are never altered.
//
// state  | meaning
// IDLE   | no frame in flight; starts one when a refresh is pending
// STREAM | presenting map(snapshot)[beat]; held until the sink accepts it
module paddle_idx_stream
  import paddle_pkg::*;
#(
  parameter int unsigned PADDLE_W = 3,
  parameter int unsigned STEP     = PADDLE_STEP,
  parameter int unsigned IDX_W    = PADDLE_IDX_W,
  parameter int unsigned POS_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POS_W-1:0] pos,
  input  logic             pend_set,
  output logic [IDX_W-1:0] stream_idx,
  output logic             stream_valid,
  input  logic             stream_ready,
  output logic             stream_last,
  output logic             busy
);

  localparam int unsigned BEAT_W = (PADDLE_W > 1) ? $clog2(PADDLE_W) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PADDLE_W - 1);

  stream_state_e     state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [POS_W-1:0]  snap_q, snap_d;
  logic              pending_q, pending_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      snap_q    <= '0;
      pending_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    snap_d    = snap_q;
    pending_d = pending_q;
    if (state_q == IDLE) begin
      if (pending_q) begin
        snap_d    = pos;
        beat_d    = '0;
        pending_d = 1'b0;
        state_d   = STREAM;
      end
    end else begin
      if (stream_ready) begin
        if (beat_q == LAST_BEAT) state_d = IDLE;
        else                     beat_d  = beat_q + 1'b1;
      end
    end
    // A change landing on the snapshot edge must still yield a follow-up frame.
    if (pend_set) pending_d = 1'b1;
  end

  assign stream_valid = (state_q == STREAM);
  assign busy         = (state_q == STREAM);
  assign stream_last  = stream_valid && (beat_q == LAST_BEAT);
  assign stream_idx   = stream_valid ? IDX_W'(paddle_map(32'(snap_q), 32'(beat_q), STEP)) : '0;

endmodule

// File: rtl/paddle_led_mapper.sv
// Paddle position register, command decode and parallel LED-index map for LED Pong.
// Define PADDLE_WRAP_EN to make moves wrap at the field ends instead of saturating.
module paddle_led_mapper
  import paddle_pkg::*;
#(
  parameter  int unsigned PADDLE_W  = 3,
  parameter  int unsigned POS_MIN   = 1,
  parameter  int unsigned POS_MAX   = 8,
  parameter  int unsigned RESET_POS = 4,
  parameter  int unsigned STEP      = PADDLE_STEP,
  parameter  int unsigned IDX_W     = PADDLE_IDX_W,
  localparam int unsigned POS_W     = $clog2(POS_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [POS_W-1:0]          pos_in,
  input  logic                      pos_load,
  input  logic                      move_up,
  input  logic                      move_down,
  output logic [POS_W-1:0]          pos_out,
  output logic [PADDLE_W*IDX_W-1:0] led_idx,
  output logic [IDX_W-1:0]          stream_idx,
  output logic                      stream_valid,
  input  logic                      stream_ready,
  output logic                      stream_last,
  output logic                      busy
);

  if ((POS_MAX + PADDLE_W - 1) * STEP >= 2 ** IDX_W) begin : g_idx_w_chk
    $error("paddle_led_mapper: IDX_W=%0d too narrow for max index %0d",
           IDX_W, (POS_MAX + PADDLE_W - 1) * STEP);
  end

  localparam logic [POS_W-1:0] P_MIN = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] P_RST = POS_W'(RESET_POS);

  function automatic logic [PADDLE_W*IDX_W-1:0] map_all(input logic [POS_W-1:0] p);
    logic [PADDLE_W*IDX_W-1:0] v;
    v = '0;
    for (int i = 0; i < PADDLE_W; i++) begin
      v[i*IDX_W +: IDX_W] = IDX_W'(paddle_map(32'(p), 32'(i), STEP));
    end
    return v;
  endfunction

  logic [POS_W-1:0]          pos_q, pos_d;
  logic [PADDLE_W*IDX_W-1:0] led_idx_q, led_idx_d;
  logic                      pend_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q     <= P_RST;
      led_idx_q <= map_all(P_RST);
    end else begin
      pos_q     <= pos_d;
      led_idx_q <= led_idx_d;
    end
  end

  // Load beats any move; opposing moves cancel; a saturated move is silent.
  always_comb begin
    pos_d    = pos_q;
    pend_set = 1'b0;
    if (pos_load) begin
      pend_set = 1'b1;
      if (pos_in < P_MIN || pos_in > P_MAX) pos_d = P_RST;
      else                                  pos_d = pos_in;
    end else if (move_up && !move_down) begin
      if (pos_q < P_MAX) begin
        pos_d    = pos_q + 1'b1;
        pend_set = 1'b1;
      end
`ifdef PADDLE_WRAP_EN
      else begin
        pos_d    = P_MIN;
        pend_set = 1'b1;
      end
`endif
    end else if (move_down && !move_up) begin
      if (pos_q > P_MIN) begin
        pos_d    = pos_q - 1'b1;
        pend_set = 1'b1;
      end
`ifdef PADDLE_WRAP_EN
      else begin
        pos_d    = P_MAX;
        pend_set = 1'b1;
      end
`endif
    end
    led_idx_d = map_all(pos_d);
  end

  assign pos_out = pos_q;
  assign led_idx = led_idx_q;

  paddle_idx_stream #(
    .PADDLE_W (PADDLE_W),
    .STEP     (STEP),
    .IDX_W    (IDX_W),
    .POS_W    (POS_W)
  ) u_stream (
    .clk          (clk),
    .rst_n        (rst_n),
    .pos          (pos_q),
    .pend_set     (pend_set),
    .stream_idx   (stream_idx),
    .stream_valid (stream_valid),
    .stream_ready (stream_ready),
    .stream_last  (stream_last),
    .busy         (busy)
  );

endmodule

// File: tb/tb_paddle_led_mapper.sv
// Directed bench for paddle_led_mapper: command table plus stream corner sequences.
module tb_paddle_led_mapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pos_in;
  logic        pos_load, move_up, move_down;
  logic [3:0]  pos_out;
  logic [26:0] led_idx;
  logic [8:0]  stream_idx;
  logic        stream_valid, stream_ready, stream_last, busy;

  int errors = 0;
  int checks = 0;

`ifdef PADDLE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    logic       load;
    logic       up;
    logic       down;
    logic [3:0] pin;
    int         exp_sat;
    int         exp_wrap;
  } vec_t;

  typedef struct {
    logic [8:0] idx;
    logic       last;
  } beat_t;

  beat_t q[$];
  vec_t  vecs[15];

  paddle_led_mapper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pos_in       (pos_in),
    .pos_load     (pos_load),
    .move_up      (move_up),
    .move_down    (move_down),
    .pos_out      (pos_out),
    .led_idx      (led_idx),
    .stream_idx   (stream_idx),
    .stream_valid (stream_valid),
    .stream_ready (stream_ready),
    .stream_last  (stream_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Record each beat the sink will accept on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && stream_valid && stream_ready) q.push_back('{stream_idx, stream_last});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [26:0] exp_led(input int p);
    logic [26:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) v[i*9 +: 9] = 9'((p + i) * 30);
    return v;
  endfunction

  task automatic wait_beats(input string name, input int n);
    int cnt;
    cnt = 0;
    while (q.size() < n && cnt < 100) begin
      tick();
      cnt++;
    end
    check({name, "_beats"}, q.size() >= n, 1);
  endtask

  task automatic check_frame(input string name, input int p);
    beat_t b;
    for (int i = 0; i < 3; i++) begin
      if (q.size() == 0) begin
        check({name, "_missing_beat"}, 0, 1);
        return;
      end
      b = q.pop_front();
      check($sformatf("%s_idx%0d", name, i), b.idx, (p + i) * 30);
      check($sformatf("%s_last%0d", name, i), b.last, (i == 2));
    end
  endtask

  task automatic drain();
    int idle_cnt;
    idle_cnt = 0;
    for (int k = 0; k < 200 && idle_cnt < 3; k++) begin
      tick();
      idle_cnt = busy ? 0 : idle_cnt + 1;
    end
    check("drain_idle", idle_cnt >= 3, 1);
    q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd9,  4, 4};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd0,  4, 4};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd8,  8, 8};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'd4,  4, 4};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd0,  5, 5};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd0,  6, 6};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd0,  7, 7};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'd0,  8, 8};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'd0,  8, 1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'd0,  8, 2};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 4'd0,  8, 2};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'd2,  2, 2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 4'd0,  1, 1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 4'd0,  1, 8};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 4'd15, 4, 4};

    rst_n = 1'b0; pos_in = '0; pos_load = 0; move_up = 0; move_down = 0; stream_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_pos", pos_out, 4);
    check("rst_led", led_idx, exp_led(4));
    check("rst_valid", stream_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_last", stream_last, 0);
    check("rst_idx", stream_idx, 0);

    // Reset release streams the reset-position frame.
    rst_n = 1'b1;
    tick();
    check("t1_valid", stream_valid, 1);
    check("t1_busy", busy, 1);
    check("t1_first_idx", stream_idx, 120);
    wait_beats("t1", 3);
    check_frame("t1", 4);
    check("t1_busy_low", busy, 0);
    check("t1_pos", pos_out, 4);

    // Load 1.
    pos_in = 4'd1; pos_load = 1'b1;
    tick();
    pos_load = 1'b0;
    check("t2_pos", pos_out, 1);
    check("t2_led", led_idx, {9'd90, 9'd60, 9'd30});
    wait_beats("t2", 3);
    check_frame("t2", 1);
    drain();

    // Command table: loads, saturation/wrap, priority.
    for (int v = 0; v < 15; v++) begin
      pos_load = vecs[v].load; move_up = vecs[v].up; move_down = vecs[v].down; pos_in = vecs[v].pin;
      tick();
      pos_load = 0; move_up = 0; move_down = 0;
      check($sformatf("vec%0d_pos", v), pos_out, WRAP ? vecs[v].exp_wrap : vecs[v].exp_sat);
      check($sformatf("vec%0d_led", v), led_idx,
            exp_led(WRAP ? vecs[v].exp_wrap : vecs[v].exp_sat));
    end
    drain();

    // Opposing moves: no change, no frame.
    begin
      logic busy_seen;
      busy_seen = 1'b0;
      move_up = 1; move_down = 1;
      tick();
      move_up = 0; move_down = 0;
      check("t4_pos", pos_out, 4);
      for (int k = 0; k < 8; k++) begin
        tick();
        busy_seen |= busy;
      end
      check("t4_no_busy", busy_seen, 0);
      check("t4_no_beats", q.size(), 0);
    end

    // Stall mid-frame with two moves; one follow-up frame at pos+2.
    stream_ready = 1'b0;
    pos_in = 4'd3; pos_load = 1'b1;
    tick();
    pos_load = 1'b0;
    tick();
    check("t5_valid", stream_valid, 1);
    check("t5_idx0", stream_idx, 90);
    stream_ready = 1'b1;
    tick();
    stream_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      move_up = (k == 1 || k == 3);
      tick();
      move_up = 0;
      check($sformatf("t5_stall_idx%0d", k), stream_idx, 120);
      check($sformatf("t5_stall_valid%0d", k), stream_valid, 1);
    end
    check("t5_pos", pos_out, 5);
    stream_ready = 1'b1;
    wait_beats("t5", 6);
    check_frame("t5a", 3);
    check_frame("t5b", 5);
    for (int k = 0; k < 10; k++) tick();
    check("t5_no_extra", q.size(), 0);
    check("t5_idle", busy, 0);

    // Reset on beat 2 aborts the frame.
    pos_in = 4'd2; pos_load = 1'b1;
    tick();
    pos_load = 1'b0;
    tick(); tick(); tick();
    check("t6_beat2", stream_idx, 120);
    rst_n = 1'b0;
    #1;
    check("t6_valid", stream_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_pos", pos_out, 4);
    check("t6_partial", q.size(), 2);
    tick(); tick();
    q.delete();
    rst_n = 1'b1;
    wait_beats("t6", 3);
    check_frame("t6", 4);
    for (int k = 0; k < 5; k++) tick();
    check("t6_no_extra", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
